// File: rtl/sensor_conditioner_if.sv
// sensor_conditioner_if: raw switch inputs and conditioned outputs of the sensor conditioner
interface sensor_conditioner_if;
  logic raw_high;
  logic raw_middle;
  logic raw_low;
  logic raw_umidadeDoSolo;
  logic raw_umidadeDoAr;
  logic raw_temperatura;
  logic raw_seletor;
  logic high;
  logic middle;
  logic low;
  logic umidadeDoSolo;
  logic umidadeDoAr;
  logic temperatura;
  logic seletor;
  logic pronto;
  modport master (
    output raw_high, raw_middle, raw_low, raw_umidadeDoSolo, raw_umidadeDoAr, raw_temperatura, raw_seletor,
    input  high, middle, low, umidadeDoSolo, umidadeDoAr, temperatura, seletor, pronto
  );
  modport slave (
    input  raw_high, raw_middle, raw_low, raw_umidadeDoSolo, raw_umidadeDoAr, raw_temperatura, raw_seletor,
    output high, middle, low, umidadeDoSolo, umidadeDoAr, temperatura, seletor, pronto
  );
endinterface

// File: rtl/sensor_conditioner.sv
// sensor_conditioner: synchronise and debounce seven raw switches, latch display select, flag readiness
module sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  sensor_conditioner_if.slave io
);
  localparam logic [CNT_W-1:0] last_cnt = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W:0] pronto_at = (CNT_W + 1)'(DEBOUNCE_CYCLES + 2);
  logic [6:0] raw;
  logic [6:0] s1;
  logic [6:0] s2;
  logic [6:0] stable;
  logic [6:0] done;
  logic [CNT_W-1:0] cnt [7];
  logic [CNT_W:0] pcnt;
  logic seletor;
  logic pronto;
  assign raw = {io.raw_seletor, io.raw_temperatura, io.raw_umidadeDoAr, io.raw_umidadeDoSolo,
                io.raw_low, io.raw_middle, io.raw_high};
  for (genvar c = 0; c < 7; c++) begin : g_done
    assign done[c] = (s2[c] != stable[c]) && (cnt[c] == last_cnt);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      stable <= '0;
      for (int i = 0; i < 7; i++) cnt[i] <= '0;
      seletor <= 1'b0;
      pronto <= 1'b0;
      pcnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 7; i++) begin
        cnt[i] <= (s2[i] == stable[i] || done[i]) ? '0 : cnt[i] + 1'b1;
        if (done[i]) stable[i] <= s2[i];
      end
      if (done[6] && s2[6]) seletor <= ~seletor;
      if (!pronto) pcnt <= pcnt + 1'b1;
      pronto <= pronto | (pcnt == pronto_at);
    end
  end
  assign io.high = stable[0];
  assign io.middle = stable[1];
  assign io.low = stable[2];
  assign io.umidadeDoSolo = stable[3];
  assign io.umidadeDoAr = stable[4];
  assign io.temperatura = stable[5];
  assign io.seletor = seletor;
  assign io.pronto = pronto;
endmodule

// File: tb/tb_sensor_conditioner.sv
// tb_sensor_conditioner: directed and random stimulus checked against a history-based reference model
module tb_sensor_conditioner;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] raw = '0;
  int checks = 0;
  int errors = 0;
  logic [6:0] hist[$];
  logic [6:0] m_out = '0;
  int run[7];
  int presses = 0;
  int edges = 0;
  sensor_conditioner_if io();
  sensor_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (.clk(clk), .reset(reset), .io(io));
  assign io.raw_high = raw[0];
  assign io.raw_middle = raw[1];
  assign io.raw_low = raw[2];
  assign io.raw_umidadeDoSolo = raw[3];
  assign io.raw_umidadeDoAr = raw[4];
  assign io.raw_temperatura = raw[5];
  assign io.raw_seletor = raw[6];
  always #5 clk = ~clk;

  task automatic expect_bits(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Each output follows the raw input as seen two edges later, flipping once that
  // delayed view has disagreed with it for D consecutive edges.
  task automatic model_edge();
    logic [6:0] seen;
    if (reset) begin
      hist.delete();
      m_out = '0;
      for (int i = 0; i < 7; i++) run[i] = 0;
      presses = 0;
      edges = 0;
    end else begin
      edges++;
      hist.push_back(raw);
      seen = hist.size() >= 3 ? hist[hist.size() - 3] : 7'b0;
      if (hist.size() > 3) void'(hist.pop_front());
      for (int i = 0; i < 7; i++) begin
        if (seen[i] != m_out[i]) begin
          run[i]++;
          if (run[i] == D) begin
            m_out[i] = seen[i];
            run[i] = 0;
            if (i == 6 && seen[i]) presses++;
          end
        end else run[i] = 0;
      end
    end
  endtask

  task automatic tick();
    logic [6:0] obs;
    @(posedge clk);
    model_edge();
    #1;
    obs = {io.seletor, io.temperatura, io.umidadeDoAr, io.umidadeDoSolo, io.low, io.middle, io.high};
    expect_bits("model_outputs", {1'b0, obs}, {1'b0, presses[0], m_out[5:0]});
    expect_bits("model_pronto", {7'b0, io.pronto}, {7'b0, edges >= D + 3});
  endtask

  function automatic logic [7:0] all_out();
    return {io.pronto, io.seletor, io.temperatura, io.umidadeDoAr, io.umidadeDoSolo, io.low, io.middle, io.high};
  endfunction

  initial begin
    reset = 1'b1;
    raw = '0;
    tick();
    tick();
    expect_bits("reset_state", all_out(), 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_bits("pronto_rise", {7'b0, io.pronto}, {7'b0, i >= 6});
      expect_bits("idle_levels", {1'b0, all_out()[6:0]}, 8'h00);
    end
    raw[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_bits("middle_latency", {7'b0, io.middle}, {7'b0, i >= 5});
      expect_bits("middle_isolated", {1'b0, all_out()[6:2], all_out()[0]}, 8'h00);
    end
    for (int p = 0; p < 5; p++) begin
      raw[2] = 1'b1;
      repeat (3) begin
        tick();
        expect_bits("low_glitch", {7'b0, io.low}, 8'h00);
      end
      raw[2] = 1'b0;
      repeat (3) begin
        tick();
        expect_bits("low_glitch", {7'b0, io.low}, 8'h00);
      end
    end
    raw[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_bits("low_latency", {7'b0, io.low}, {7'b0, i >= 5});
    end
    raw[6] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_bits("sel_press1", {7'b0, io.seletor}, {7'b0, i >= 5});
    end
    raw[6] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_bits("sel_release", {7'b0, io.seletor}, 8'h01);
    end
    raw[6] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_bits("sel_press2", {7'b0, io.seletor}, {7'b0, i < 5});
    end
    raw[6] = 1'b0;
    repeat (10) tick();
    raw[6] = 1'b1;
    repeat (20) tick();
    expect_bits("sel_third", {7'b0, io.seletor}, 8'h01);
    raw[5] = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    expect_bits("mid_reset", all_out(), 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_bits("temp_after_reset", {7'b0, io.temperatura}, {7'b0, i >= 5});
      expect_bits("pronto_after_reset", {7'b0, io.pronto}, {7'b0, i >= 6});
    end
    raw = '0;
    repeat (10) tick();
    raw[0] = 1'b1;
    raw[4] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 1) raw[0] = 1'b0;
      if (i == 2) raw[0] = 1'b1;
      expect_bits("ar_latency", {7'b0, io.umidadeDoAr}, {7'b0, i >= 5});
      expect_bits("high_bounce", {7'b0, io.high}, {7'b0, i >= 8});
    end
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 7; b++) if ($urandom_range(0, 5) == 0) raw[b] = ~raw[b];
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
